id_ex_fwd_stage: RTL

//  ID/EX pipeline register of the 64-bit core. Feeds the EX-stage 3:1 operand muxes.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/id_ex_fwd_stage_if.sv | 55 +++++
 rtl/id_ex_fwd_stage_fwd_unit.sv | 26 ++
 rtl/id_ex_fwd_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types, widths and forwarding-select encodings.
// Imported by the ID/EX stage, its interface and the forwarding unit.
package pipe_pkg;

    localparam int XLEN    = 64;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;
    localparam int CTRL_W  = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // x0 is hardwired zero, so a write to it never produces a usable value.
    function automatic logic rd_hit(
        input logic              rw,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] src
    );
        return rw && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/id_ex_fwd_stage_if.sv
// Bundle between decode/later stages and the ID/EX register.
// master drives ID and bypass inputs; slave is the ID/EX stage.
interface id_ex_fwd_stage_if;
    import pipe_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [XLEN-1:0]   id_pc;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic [REG_AW-1:0] ex_mem_rd;
    logic              ex_mem_rw;
    logic [REG_AW-1:0] mem_wb_rd;
    logic              mem_wb_rw;
    logic [XLEN-1:0]   mem_wb_data;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_pc;
    logic [REG_AW-1:0] ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              hazard_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_rs1_data, id_rs2_data, id_imm, id_pc,
        output id_ctrl, flush,
        output ex_mem_rd, ex_mem_rw,
        output mem_wb_rd, mem_wb_rw, mem_wb_data,
        input  ex_valid, ex_rs1_data, ex_rs2_data,
        input  ex_imm, ex_pc, ex_rd, ex_ctrl,
        input  fwd_a_sel, fwd_b_sel, hazard_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_rs1_data, id_rs2_data, id_imm, id_pc,
        input  id_ctrl, flush,
        input  ex_mem_rd, ex_mem_rw,
        input  mem_wb_rd, mem_wb_rw, mem_wb_data,
        output ex_valid, ex_rs1_data, ex_rs2_data,
        output ex_imm, ex_pc, ex_rd, ex_ctrl,
        output fwd_a_sel, fwd_b_sel, hazard_stall
    );

endinterface

// File: rtl/id_ex_fwd_stage_fwd_unit.sv
// Operand forwarding select for one EX source register.
// EX/MEM has priority over MEM/WB; 2'b11 cannot be produced.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic              valid_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] ex_mem_rd_i,
    input  logic              ex_mem_rw_i,
    input  logic [REG_AW-1:0] mem_wb_rd_i,
    input  logic              mem_wb_rw_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (valid_i) begin
            if (rd_hit(ex_mem_rw_i, ex_mem_rd_i, src_i)) begin
                sel_o = FWD_MEM;
            end else if (rd_hit(mem_wb_rw_i, mem_wb_rd_i, src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use bubble and forwarding selects.
// Optional WB_BYPASS_EN: write-before-read bypass of MEM/WB data on capture.
module id_ex_fwd_stage
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    id_ex_fwd_stage_if.slave   bus
);

    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;

    logic              hazard;
    logic [XLEN-1:0]   rs1_cap;
    logic [XLEN-1:0]   rs2_cap;

    assign hazard = ex_valid_q && ex_ctrl_q.mem_read &&
                    (ex_rd_q != '0) &&
                    ((ex_rd_q == bus.id_rs1) ||
                     (ex_rd_q == bus.id_rs2)) &&
                    bus.id_valid;

`ifdef WB_BYPASS_EN
    assign rs1_cap = rd_hit(bus.mem_wb_rw, bus.mem_wb_rd, bus.id_rs1)
                   ? bus.mem_wb_data : bus.id_rs1_data;
    assign rs2_cap = rd_hit(bus.mem_wb_rw, bus.mem_wb_rd, bus.id_rs2)
                   ? bus.mem_wb_data : bus.id_rs2_data;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^bus.mem_wb_data;
    assign rs1_cap = bus.id_rs1_data;
    assign rs2_cap = bus.id_rs2_data;
`endif

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;
        ex_pc_d       = ex_pc_q;
        ex_rd_d       = ex_rd_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        // Flush and load-use stall both insert a bubble; data fields hold.
        if (bus.flush || hazard) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else begin
            ex_valid_d    = bus.id_valid;
            ex_ctrl_d     = bus.id_valid ? ctrl_t'(bus.id_ctrl) : '0;
            ex_rs1_data_d = rs1_cap;
            ex_rs2_data_d = rs2_cap;
            ex_imm_d      = bus.id_imm;
            ex_pc_d       = bus.id_pc;
            ex_rd_d       = bus.id_rd;
            ex_rs1_d      = bus.id_rs1;
            ex_rs2_d      = bus.id_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc_q       <= ex_pc_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
        end
    end

    fwd_unit u_fwd_a (
        .valid_i     (ex_valid_q),
        .src_i       (ex_rs1_q),
        .ex_mem_rd_i (bus.ex_mem_rd),
        .ex_mem_rw_i (bus.ex_mem_rw),
        .mem_wb_rd_i (bus.mem_wb_rd),
        .mem_wb_rw_i (bus.mem_wb_rw),
        .sel_o       (bus.fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .valid_i     (ex_valid_q),
        .src_i       (ex_rs2_q),
        .ex_mem_rd_i (bus.ex_mem_rd),
        .ex_mem_rw_i (bus.ex_mem_rw),
        .mem_wb_rd_i (bus.mem_wb_rd),
        .mem_wb_rw_i (bus.mem_wb_rw),
        .sel_o       (bus.fwd_b_sel)
    );

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_rs1_data  = ex_rs1_data_q;
    assign bus.ex_rs2_data  = ex_rs2_data_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.hazard_stall = hazard;

endmodule
